// File: rtl/carousel_lane_collector.sv
// Carousel receive end: steers tagged slot tokens into per-lane FIFOs.
// Each lane arbitrates round-robin among the slots that target it.
module carousel_lane_collector #(
    parameter int WIDTH       = 8,
    parameter int BUFFER_SIZE = 3,
    parameter int FIFO_DEPTH  = 4,
    localparam int TAG_W =
        (BUFFER_SIZE > 2) ? $clog2(BUFFER_SIZE) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       data_in        [BUFFER_SIZE],
    input  logic [TAG_W-1:0]       data_in_dest   [BUFFER_SIZE],
    input  logic [BUFFER_SIZE-1:0] data_in_valid,
    output logic [BUFFER_SIZE-1:0] data_in_ready,
    output logic [WIDTH-1:0]       data_out       [BUFFER_SIZE],
    output logic [BUFFER_SIZE-1:0] data_out_valid,
    input  logic [BUFFER_SIZE-1:0] data_out_ready,
    output logic [15:0]            drop_count
);

    localparam int N     = BUFFER_SIZE;
    localparam int PTR_W =
        (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [WIDTH-1:0] mem    [N][FIFO_DEPTH];
    logic [PTR_W-1:0] wptr   [N];
    logic [PTR_W-1:0] rptr   [N];
    logic [CNT_W-1:0] cnt    [N];
    logic [TAG_W-1:0] rr_ptr [N];

    logic [N-1:0]     gnt    [N];
    logic [TAG_W-1:0] src    [N];
    logic [N-1:0]     push;
    logic [N-1:0]     pop;
    logic [N-1:0]     hit;
    logic [N-1:0]     drop;
    logic [16:0]      drop_sum;

    function automatic logic [PTR_W-1:0] ptr_inc(
        input logic [PTR_W-1:0] p
    );
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Search from rr_ptr; the first requester stops the search
    // even when the lane is full, so no lower-priority slot wins.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            gnt[j]  = '0;
            src[j]  = '0;
            push[j] = 1'b0;
            hit[j]  = 1'b0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = int'(rr_ptr[j]) + k;
                if (idx >= N) idx = idx - N;
                if (!hit[j] && data_in_valid[idx] &&
                    data_in_dest[idx] == TAG_W'(j)) begin
                    hit[j] = 1'b1;
                    if (cnt[j] < CNT_W'(FIFO_DEPTH)) begin
                        gnt[j][idx] = 1'b1;
                        src[j]      = TAG_W'(idx);
                        push[j]     = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            drop[i] = data_in_valid[i] &&
                      (int'(data_in_dest[i]) >= N);
            data_in_ready[i] = drop[i];
            for (int j = 0; j < N; j++) begin
                if (gnt[j][i]) data_in_ready[i] = 1'b1;
            end
            data_in_ready[i] = data_in_ready[i] & rst_n;
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++) begin
            data_out_valid[j] = (cnt[j] != '0);
            pop[j]            = data_out_valid[j] &
                                data_out_ready[j];
            data_out[j]       = mem[j][rptr[j]];
        end
        drop_sum = 17'(drop_count) + 17'($countones(drop));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N; j++) begin
                wptr[j]   <= '0;
                rptr[j]   <= '0;
                cnt[j]    <= '0;
                rr_ptr[j] <= '0;
                for (int d = 0; d < FIFO_DEPTH; d++) begin
                    mem[j][d] <= '0;
                end
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                if (push[j]) begin
                    mem[j][wptr[j]] <= data_in[src[j]];
                    wptr[j]         <= ptr_inc(wptr[j]);
                    rr_ptr[j]       <=
                        (src[j] == TAG_W'(N - 1)) ? '0
                                                  : src[j] + 1'b1;
                end
                if (pop[j]) rptr[j] <= ptr_inc(rptr[j]);
                cnt[j] <= cnt[j] + CNT_W'(push[j])
                                 - CNT_W'(pop[j]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (drop_sum > 17'h0FFFF) begin
            drop_count <= 16'hFFFF;
        end else begin
            drop_count <= drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_carousel_lane_collector.sv
// Randomized scoreboard bench for carousel_lane_collector.
// Reference model: per-lane token queues plus rotating priority.
module tb_carousel_lane_collector;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in        [3];
    logic [1:0] data_in_dest   [3];
    logic [2:0] data_in_valid;
    logic [2:0] data_in_ready;
    logic [7:0] data_out       [3];
    logic [2:0] data_out_valid;
    logic [2:0] data_out_ready;
    logic [15:0] drop_count;

    carousel_lane_collector #(
        .WIDTH(8), .BUFFER_SIZE(3), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_in(data_in),
        .data_in_dest(data_in_dest),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .data_out(data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] exp_q [3][$];
    int         rr [3];
    int         drops;
    logic [2:0] acc;
    bit         run;

    int p_valid, p_bad, p_rdy, fixed_dest;

    task automatic check(input string name,
                         input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Upstream: hold each token until accepted, then maybe replace.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (!data_in_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 99) < p_valid) begin
                        data_in_valid[i] = 1'b1;
                        data_in[i] = 8'($urandom);
                        if ($urandom_range(0, 99) < p_bad)
                            data_in_dest[i] = 2'd3;
                        else if (fixed_dest >= 0)
                            data_in_dest[i] = 2'(fixed_dest);
                        else
                            data_in_dest[i] = 2'($urandom_range(0, 2));
                    end else begin
                        data_in_valid[i] = 1'b0;
                    end
                end
            end
            for (int j = 0; j < 3; j++)
                data_out_ready[j] = ($urandom_range(0, 99) < p_rdy);
        end
    end

    // Acceptance model: which slots are taken this cycle.
    always @(negedge clk) begin
        logic [2:0] er;
        logic [2:0] pe;
        logic [7:0] pv [3];
        int         rn [3];
        int         nb;
        bit         found;
        int         s;
        if (rst_n && run) begin
            er = '0;
            pe = '0;
            nb = 0;
            for (int j = 0; j < 3; j++) begin
                rn[j] = rr[j];
                pv[j] = '0;
                found = 0;
                for (int k = 0; k < 3; k++) begin
                    s = (rr[j] + k) % 3;
                    if (!found && data_in_valid[s] &&
                        int'(data_in_dest[s]) == j) begin
                        found = 1;
                        if (exp_q[j].size() < 4) begin
                            er[s] = 1'b1;
                            pe[j] = 1'b1;
                            pv[j] = data_in[s];
                            rn[j] = (s + 1) % 3;
                        end
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (data_in_valid[i] && data_in_dest[i] == 2'd3) begin
                    er[i] = 1'b1;
                    nb++;
                end
            end
            check("data_in_ready", int'(data_in_ready), int'(er));
            check("drop_count", int'(drop_count), drops);
            @(posedge clk);
            if (rst_n) begin
                for (int j = 0; j < 3; j++) begin
                    if (pe[j]) exp_q[j].push_back(pv[j]);
                    rr[j] = rn[j];
                end
                drops = (drops + nb > 65535) ? 65535 : drops + nb;
                acc   = er;
            end
        end
    end

    // Output monitor: compare each lane head, retire on pop.
    always @(negedge clk) begin
        logic [2:0] pp;
        if (rst_n && run) begin
            pp = '0;
            for (int j = 0; j < 3; j++) begin
                check($sformatf("out_valid[%0d]", j),
                      int'(data_out_valid[j]),
                      int'(exp_q[j].size() > 0));
                if (exp_q[j].size() > 0) begin
                    check($sformatf("data_out[%0d]", j),
                          int'(data_out[j]), int'(exp_q[j][0]));
                    pp[j] = data_out_ready[j];
                end
            end
            @(posedge clk);
            if (rst_n) begin
                for (int j = 0; j < 3; j++)
                    if (pp[j] && exp_q[j].size() > 0)
                        void'(exp_q[j].pop_front());
            end
        end
    end

    task automatic phase(input int pv, input int pb, input int pr,
                         input int fd, input int cycles);
        p_valid    = pv;
        p_bad      = pb;
        p_rdy      = pr;
        fixed_dest = fd;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic clear_model();
        for (int j = 0; j < 3; j++) begin
            exp_q[j].delete();
            rr[j] = 0;
        end
        drops = 0;
        acc   = '0;
    endtask

    initial begin
        run = 0;
        rst_n = 1'b0;
        p_valid = 0; p_bad = 0; p_rdy = 0; fixed_dest = -1;
        data_in_valid = '0;
        data_out_ready = '0;
        for (int i = 0; i < 3; i++) begin
            data_in[i] = '0;
            data_in_dest[i] = '0;
        end
        clear_model();
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            data_in[i] = 8'(8'h10 + i);
            data_in_dest[i] = 2'(i);
        end
        data_in_valid = 3'b111;
        data_out_ready = 3'b111;
        #1;
        check("rst ready", int'(data_in_ready), 0);
        check("rst out_valid", int'(data_out_valid), 0);
        check("rst drop_count", int'(drop_count), 0);
        for (int j = 0; j < 3; j++)
            check("rst data_out", int'(data_out[j]), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        run = 1;

        phase(60, 10, 70, -1, 400);
        phase(100, 0, 100, 1, 60);
        phase(90, 0, 0, 0, 30);
        phase(80, 0, 20, -1, 300);
        phase(100, 0, 100, -1, 200);
        phase(100, 100, 100, -1, 21900);
        phase(50, 10, 50, -1, 200);
        phase(90, 0, 0, 0, 20);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", int'(data_out_valid), 0);
        check("midrst ready", int'(data_in_ready), 0);
        check("midrst drop_count", int'(drop_count), 0);
        clear_model();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("post rst out_valid", int'(data_out_valid), 0);
        phase(70, 10, 60, -1, 300);
        phase(0, 0, 100, -1, 20);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
